// File: rtl/bus_cdc_bridge_pkg.sv
// Shared widths and FSM encoding for the CPU-side toggle-handshake bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_cdc_bridge_pkg;

  localparam int unsigned address_width = 32;
  localparam int unsigned data_width    = 32;

  // IDLE: waiting for a hit; WAIT: request outstanding; DONE: one-cycle completion
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_cdc_state_t;

endpackage

// File: rtl/bus_cdc_bridge_if.sv
// CPU bus slave signals plus the far-side request/acknowledge bundle of the bridge.
// Latency: n/a (wiring only).
// Backpressure: cpu_halt_o is the only stall; tgt_* signals form a toggle handshake.
interface bus_cdc_bridge_if
  import bus_cdc_bridge_pkg::*;
#(
  parameter int unsigned AddrWidth = address_width,
  parameter int unsigned DataWidth = data_width
);

  // CPU bus side
  logic [AddrWidth-1:0] cpu_address_i;
  logic [DataWidth-1:0] cpu_wdata_i;
  logic                 cpu_we_i;
  logic [DataWidth-1:0] cpu_rdata_o;
  logic                 cpu_halt_o;

  // far-side target bundle
  logic                 tgt_req_o;
  logic [AddrWidth-1:0] tgt_address_o;
  logic [DataWidth-1:0] tgt_wdata_o;
  logic                 tgt_we_o;
  logic                 tgt_ack_i;
  logic [DataWidth-1:0] tgt_rdata_i;

  // sticky status
  logic                 timeout_o;

  // the bridge itself
  modport slave (
    input  cpu_address_i, cpu_wdata_i, cpu_we_i, tgt_ack_i, tgt_rdata_i,
    output cpu_rdata_o, cpu_halt_o, tgt_req_o, tgt_address_o, tgt_wdata_o,
    tgt_we_o, timeout_o
  );

  // the CPU / far-side environment around the bridge
  modport master (
    output cpu_address_i, cpu_wdata_i, cpu_we_i, tgt_ack_i, tgt_rdata_i,
    input  cpu_rdata_o, cpu_halt_o, tgt_req_o, tgt_address_o, tgt_wdata_o,
    tgt_we_o, timeout_o
  );

endinterface

// File: rtl/bus_cdc_bridge_sync_2ff.sv
// Two-flop synchronizer for signals arriving from a foreign clock domain.
// Latency: 2 clk_i edges from a settled input change to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] s1_q;
  logic [Width-1:0] s2_q;

  // shift the asynchronous input through two stages to resolve metastability
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/bus_cdc_bridge.sv
// CPU-clock bridge: forwards accesses in one address window to a far-side target via req/ack toggles.
// Latency: req toggles 1 edge after a hit; DONE 2 edges after the ack toggle is first sampled.
// Backpressure: cpu_halt_o holds the CPU from the hit cycle until the single DONE cycle.
module bus_cdc_bridge
  import bus_cdc_bridge_pkg::*;
#(
  parameter int unsigned          AddrWidth     = address_width,
  parameter int unsigned          DataWidth     = data_width,
  parameter logic [AddrWidth-1:0] StartAddress  = '0,
  parameter logic [AddrWidth-1:0] EndAddress    = '0,
  parameter int unsigned          TimeoutCycles = 4096
) (
  input logic             clk_i,
  input logic             reset_i,
  bus_cdc_bridge_if.slave bus
);

  localparam int unsigned         CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TimeoutCycles - 1);

  bus_cdc_state_t state_q;
  bus_cdc_state_t state_d;

  logic                 hit;
  logic                 halt_d;
  logic                 ack_s2;
  logic                 ack_edge;
  logic                 start_acc;
  logic                 end_ack;
  logic                 end_timeout;

  logic                 req_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 we_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 ack_seen_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 timeout_q;

  // Window bounds are passed as arguments so a zero-based window does not
  // collapse into a constant comparison.
  function automatic logic in_window(input logic [AddrWidth-1:0] a,
                                     input logic [AddrWidth-1:0] lo,
                                     input logic [AddrWidth-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  assign hit = in_window(bus.cpu_address_i, StartAddress, EndAddress);

  // the acknowledge toggle comes from the far clock domain
  sync_2ff #(
    .Width (1)
  ) u_ack_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (bus.tgt_ack_i),
    .q       (ack_s2)
  );

  assign ack_edge = (ack_s2 != ack_seen_q);

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, access start/finish strobes and halt request
  always_comb begin
    state_d     = state_q;
    start_acc   = 1'b0;
    end_ack     = 1'b0;
    end_timeout = 1'b0;
    halt_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        halt_d = hit;
        if (hit) begin
          start_acc = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        halt_d = 1'b1;
        // an ack arriving in the last allowed cycle still wins over the timeout
        if (ack_edge) begin
          end_ack = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CntLast) begin
          end_timeout = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // capture the request bundle and flip the request toggle once per access
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (start_acc) begin
      req_q   <= ~req_q;
      addr_q  <= bus.cpu_address_i;
      wdata_q <= bus.cpu_wdata_i;
      we_q    <= bus.cpu_we_i;
    end
  end

  // track the synchronized ack level; resync in IDLE discards stale or late toggles
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ack_seen_q <= 1'b0;
    end else if ((state_q == ST_IDLE) || end_ack) begin
      ack_seen_q <= ack_s2;
    end
  end

  // count cycles spent waiting for the acknowledge
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (start_acc) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // read data holding register: loaded on a read ack, zero otherwise
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rdata_q <= '0;
    end else if (end_ack) begin
      rdata_q <= we_q ? '0 : bus.tgt_rdata_i;
    end else if (end_timeout || (state_q == ST_DONE)) begin
      rdata_q <= '0;
    end
  end

  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      timeout_q <= 1'b0;
    end else if (end_timeout) begin
      timeout_q <= 1'b1;
    end
  end

  // Halt is gated by reset so the CPU is never stalled while the bridge is held in reset.
  assign bus.cpu_halt_o    = reset_i & halt_d;
  // Zero outside a read completion so the bus can OR this slave with others.
  assign bus.cpu_rdata_o   = ((state_q == ST_DONE) && !we_q) ? rdata_q : '0;
  assign bus.tgt_req_o     = req_q;
  assign bus.tgt_address_o = addr_q;
  assign bus.tgt_wdata_o   = wdata_q;
  assign bus.tgt_we_o      = we_q;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_bus_cdc_bridge.sv
// Directed bench for bus_cdc_bridge with a far-side responder on its own clock.
// Latency: n/a.
// Backpressure: responder acks a fixed number of target cycles after each request toggle.
module tb_bus_cdc_bridge;

  localparam logic [31:0] START_ADDR = 32'h0000_0100;
  localparam logic [31:0] END_ADDR   = 32'h0000_01FF;
  localparam logic [31:0] IDLE_ADDR  = 32'h0000_0000;
  localparam int          TIMEOUT    = 64;
  localparam int          LIMIT      = 200;

  logic clk = 1'b0;
  logic tgt_clk = 1'b0;
  logic rst_n = 1'b0;

  // CPU clock posedges at odd ns, target clock posedges at even ns: never coincident
  always #5 clk = ~clk;
  always #8 tgt_clk = ~tgt_clk;

  bus_cdc_bridge_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  bus_cdc_bridge #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .StartAddress  (START_ADDR),
    .EndAddress    (END_ADDR),
    .TimeoutCycles (TIMEOUT)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  // responder controls
  logic        tgt_en        = 1'b1;
  logic        tgt_rst       = 1'b1;
  int          tgt_delay     = 7;
  logic [31:0] tgt_rdata_val = 32'h0;
  int          kick_req      = 0;
  int          ack_count     = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // results of run_access
  logic        r_halt0;
  int          r_toggles;
  int          r_after_ack;
  int          r_cycles;
  logic [31:0] r_done_rdata;
  int          r_bad;
  logic        r_expired;

  // far-side responder in the target clock domain
  initial begin
    logic last_req;
    int   kick_seen;
    last_req        = 1'b0;
    kick_seen       = 0;
    bus.tgt_ack_i   = 1'b0;
    bus.tgt_rdata_i = 32'h0;
    forever begin
      @(posedge tgt_clk);
      if (tgt_rst) begin
        bus.tgt_ack_i = 1'b0;
        last_req      = bus.tgt_req_o;
      end else if (kick_req != kick_seen) begin
        kick_seen     = kick_req;
        bus.tgt_ack_i = ~bus.tgt_ack_i;
      end else if (bus.tgt_req_o !== last_req) begin
        last_req = bus.tgt_req_o;
        if (tgt_en) begin
          repeat (tgt_delay) @(posedge tgt_clk);
          bus.tgt_rdata_i = tgt_rdata_val;
          bus.tgt_ack_i   = ~bus.tgt_ack_i;
          ack_count++;
        end
      end
    end
  end

  // Drive one CPU access and hold it until halt drops; starts 2 ns after a clk posedge.
  task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wd);
    logic prev_req;
    int   ack0;
    r_toggles    = 0;
    r_after_ack  = 0;
    r_cycles     = 0;
    r_done_rdata = 32'h0;
    r_bad        = 0;
    r_expired    = 1'b1;
    prev_req     = bus.tgt_req_o;
    ack0         = ack_count;
    bus.cpu_address_i = addr;
    bus.cpu_we_i      = we;
    bus.cpu_wdata_i   = wd;
    #1 r_halt0 = bus.cpu_halt_o;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      if (ack_count != ack0) r_after_ack++;
      #2;
      r_cycles++;
      if (bus.tgt_req_o !== prev_req) begin
        r_toggles++;
        prev_req = bus.tgt_req_o;
      end
      if (bus.cpu_halt_o === 1'b0) begin
        r_done_rdata = bus.cpu_rdata_o;
        r_expired    = 1'b0;
        break;
      end
      if (bus.cpu_rdata_o !== 32'h0) r_bad++;
    end
    bus.cpu_address_i = IDLE_ADDR;
    bus.cpu_we_i      = 1'b0;
    bus.cpu_wdata_i   = 32'h0;
    @(posedge clk);
    #2;
    if (bus.tgt_req_o !== prev_req) r_toggles++;
    if (bus.cpu_rdata_o !== 32'h0 || bus.cpu_halt_o !== 1'b0) r_bad++;
  endtask

  task automatic test_reset();
    bus.cpu_address_i = START_ADDR;
    bus.cpu_we_i      = 1'b1;
    bus.cpu_wdata_i   = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (bus.cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b expected 0", bus.cpu_halt_o); end
    n_checks++; if (bus.tgt_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.tgt_req_o); end
    n_checks++; if (bus.tgt_address_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.tgt_address_o); end
    n_checks++; if (bus.tgt_wdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", bus.tgt_wdata_o); end
    n_checks++; if (bus.tgt_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", bus.tgt_we_o); end
    n_checks++; if (bus.cpu_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", bus.cpu_rdata_o); end
    n_checks++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout_o); end
    bus.cpu_address_i = IDLE_ADDR;
    bus.cpu_we_i      = 1'b0;
    bus.cpu_wdata_i   = 32'h0;
    rst_n   = 1'b1;
    tgt_rst = 1'b0;
    @(posedge clk);
    #2;
    n_checks++; if (bus.cpu_halt_o !== 1'b0 || bus.tgt_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst: got halt=%b req=%b expected 0 0", bus.cpu_halt_o, bus.tgt_req_o); end
  endtask

  task automatic test_write();
    tgt_en    = 1'b1;
    tgt_delay = 7;
    run_access(START_ADDR, 1'b1, 32'hA5A5_1234);
    n_checks++; if (r_expired !== 1'b0) begin n_fail++; $display("FAIL wr_complete: got expired=%b expected 0", r_expired); end
    n_checks++; if (r_halt0 !== 1'b1) begin n_fail++; $display("FAIL wr_halt_on_hit: got %b expected 1", r_halt0); end
    n_checks++; if (r_toggles != 1) begin n_fail++; $display("FAIL wr_toggles: got %0d expected 1", r_toggles); end
    n_checks++; if (r_after_ack != 3) begin n_fail++; $display("FAIL wr_ack_to_done: got %0d expected 3", r_after_ack); end
    n_checks++; if (bus.tgt_address_o !== START_ADDR) begin n_fail++; $display("FAIL wr_addr: got %h expected %h", bus.tgt_address_o, START_ADDR); end
    n_checks++; if (bus.tgt_wdata_o !== 32'hA5A5_1234) begin n_fail++; $display("FAIL wr_wdata: got %h expected a5a51234", bus.tgt_wdata_o); end
    n_checks++; if (bus.tgt_we_o !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b expected 1", bus.tgt_we_o); end
    n_checks++; if (r_done_rdata !== 32'h0 || r_bad != 0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h bad=%0d expected 0 0", r_done_rdata, r_bad); end
  endtask

  task automatic test_read();
    tgt_delay     = 7;
    tgt_rdata_val = 32'h0BAD_F00D;
    run_access(START_ADDR, 1'b0, 32'h0);
    n_checks++; if (r_expired !== 1'b0) begin n_fail++; $display("FAIL rd_complete: got expired=%b expected 0", r_expired); end
    n_checks++; if (r_done_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rd_data: got %h expected 0badf00d", r_done_rdata); end
    n_checks++; if (r_bad != 0) begin n_fail++; $display("FAIL rd_data_outside_done: got %0d nonzero cycles expected 0", r_bad); end
    n_checks++; if (r_toggles != 1) begin n_fail++; $display("FAIL rd_toggles: got %0d expected 1", r_toggles); end
    n_checks++; if (r_after_ack != 3) begin n_fail++; $display("FAIL rd_ack_to_done: got %0d expected 3", r_after_ack); end
    n_checks++; if (bus.tgt_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b expected 0", bus.tgt_we_o); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    logic        prev;
    int          bad;
    addrs[0] = START_ADDR - 32'd1;
    addrs[1] = END_ADDR + 32'd1;
    for (int k = 0; k < 2; k++) begin
      prev = bus.tgt_req_o;
      bus.cpu_address_i = addrs[k];
      bus.cpu_we_i      = (k == 1);
      bus.cpu_wdata_i   = 32'h1234_5678;
      #1;
      n_checks++; if (bus.cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL oor_halt addr=%h: got %b expected 0", addrs[k], bus.cpu_halt_o); end
      bad = 0;
      repeat (4) begin
        @(posedge clk);
        #2;
        if (bus.tgt_req_o !== prev || bus.cpu_halt_o !== 1'b0 || bus.cpu_rdata_o !== 32'h0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL oor_quiet addr=%h: got %0d bad cycles expected 0", addrs[k], bad); end
      bus.cpu_address_i = IDLE_ADDR;
      bus.cpu_we_i      = 1'b0;
      bus.cpu_wdata_i   = 32'h0;
    end
    tgt_delay     = 5;
    tgt_rdata_val = 32'h0000_E0DA;
    run_access(END_ADDR, 1'b0, 32'h0);
    n_checks++; if (r_expired !== 1'b0 || r_toggles != 1) begin n_fail++; $display("FAIL end_addr_access: got expired=%b toggles=%0d expected 0 1", r_expired, r_toggles); end
    n_checks++; if (r_done_rdata !== 32'h0000_E0DA) begin n_fail++; $display("FAIL end_addr_data: got %h expected 0000e0da", r_done_rdata); end
    n_checks++; if (bus.tgt_address_o !== END_ADDR) begin n_fail++; $display("FAIL end_addr_capture: got %h expected %h", bus.tgt_address_o, END_ADDR); end
  endtask

  task automatic test_back_to_back();
    logic prev;
    int   toggles;
    int   dones;
    int   bad;
    tgt_delay     = 2;
    tgt_rdata_val = 32'h1111_2222;
    prev    = bus.tgt_req_o;
    toggles = 0;
    dones   = 0;
    bad     = 0;
    bus.cpu_address_i = 32'h0000_0140;
    bus.cpu_we_i      = 1'b0;
    for (int i = 0; i < LIMIT && dones < 2; i++) begin
      @(posedge clk);
      #2;
      if (bus.tgt_req_o !== prev) begin
        toggles++;
        prev = bus.tgt_req_o;
      end
      if (bus.cpu_halt_o === 1'b0) begin
        dones++;
        if (bus.cpu_rdata_o !== 32'h1111_2222) bad++;
      end else if (bus.cpu_rdata_o !== 32'h0) begin
        bad++;
      end
    end
    bus.cpu_address_i = IDLE_ADDR;
    @(posedge clk);
    #2;
    if (bus.tgt_req_o !== prev) toggles++;
    n_checks++; if (dones != 2) begin n_fail++; $display("FAIL b2b_dones: got %0d expected 2", dones); end
    n_checks++; if (toggles != 2) begin n_fail++; $display("FAIL b2b_toggles: got %0d expected 2", toggles); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_rdata: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_timeout();
    logic prev;
    int   bad;
    tgt_en = 1'b0;
    n_checks++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_before: got %b expected 0", bus.timeout_o); end
    run_access(32'h0000_0120, 1'b0, 32'h0);
    n_checks++; if (r_expired !== 1'b0) begin n_fail++; $display("FAIL to_halt_release: got expired=%b expected 0", r_expired); end
    n_checks++; if (r_cycles != TIMEOUT + 1) begin n_fail++; $display("FAIL to_cycles: got %0d expected %0d", r_cycles, TIMEOUT + 1); end
    n_checks++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", bus.timeout_o); end
    n_checks++; if (r_done_rdata !== 32'h0 || r_bad != 0) begin n_fail++; $display("FAIL to_rdata: got %h bad=%0d expected 0 0", r_done_rdata, r_bad); end
    // late ack must be swallowed by the idle resync
    prev = bus.tgt_req_o;
    bad  = 0;
    kick_req++;
    repeat (8) begin
      @(posedge clk);
      #2;
      if (bus.tgt_req_o !== prev || bus.cpu_halt_o !== 1'b0 || bus.cpu_rdata_o !== 32'h0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL late_ack_quiet: got %0d bad cycles expected 0", bad); end
    n_checks++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", bus.timeout_o); end
    tgt_en        = 1'b1;
    tgt_delay     = 3;
    tgt_rdata_val = 32'hCAFE_0001;
    run_access(32'h0000_0120, 1'b0, 32'h0);
    n_checks++; if (r_expired !== 1'b0 || r_done_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL after_to_access: got expired=%b data=%h expected 0 cafe0001", r_expired, r_done_rdata); end
    n_checks++; if (r_after_ack != 3) begin n_fail++; $display("FAIL after_to_ack_to_done: got %0d expected 3", r_after_ack); end
  endtask

  task automatic test_reset_mid_access();
    tgt_en = 1'b0;
    bus.cpu_address_i = 32'h0000_0180;
    bus.cpu_we_i      = 1'b1;
    bus.cpu_wdata_i   = 32'hDEAD_BEEF;
    repeat (5) @(posedge clk);
    #2;
    n_checks++; if (bus.cpu_halt_o !== 1'b1 || bus.tgt_wdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mid_wait: got halt=%b wdata=%h expected 1 deadbeef", bus.cpu_halt_o, bus.tgt_wdata_o); end
    rst_n   = 1'b0;
    tgt_rst = 1'b1;
    #1;
    n_checks++; if (bus.cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_halt: got %b expected 0", bus.cpu_halt_o); end
    n_checks++; if (bus.tgt_req_o !== 1'b0 || bus.tgt_we_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req_we: got req=%b we=%b expected 0 0", bus.tgt_req_o, bus.tgt_we_o); end
    n_checks++; if (bus.tgt_address_o !== 32'h0 || bus.tgt_wdata_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_bundle: got addr=%h wdata=%h expected 0 0", bus.tgt_address_o, bus.tgt_wdata_o); end
    n_checks++; if (bus.timeout_o !== 1'b0 || bus.cpu_rdata_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_status: got timeout=%b rdata=%h expected 0 0", bus.timeout_o, bus.cpu_rdata_o); end
    bus.cpu_address_i = IDLE_ADDR;
    bus.cpu_we_i      = 1'b0;
    bus.cpu_wdata_i   = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst_n         = 1'b1;
    tgt_rst       = 1'b0;
    tgt_en        = 1'b1;
    tgt_delay     = 4;
    tgt_rdata_val = 32'h5A5A_0F0F;
    @(posedge clk);
    #2;
    run_access(32'h0000_0180, 1'b0, 32'h0);
    n_checks++; if (r_expired !== 1'b0 || r_toggles != 1) begin n_fail++; $display("FAIL post_rst_access: got expired=%b toggles=%0d expected 0 1", r_expired, r_toggles); end
    n_checks++; if (r_done_rdata !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL post_rst_data: got %h expected 5a5a0f0f", r_done_rdata); end
    n_checks++; if (bus.tgt_address_o !== 32'h0000_0180) begin n_fail++; $display("FAIL post_rst_addr: got %h expected 00000180", bus.tgt_address_o); end
  endtask

  initial begin
    bus.cpu_address_i = IDLE_ADDR;
    bus.cpu_we_i      = 1'b0;
    bus.cpu_wdata_i   = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cdc_bridge.md
# bus_cdc_bridge

CPU-side half of a four-phase-free toggle-handshake bus bridge. It claims one address window of the CPU bus and holds the CPU with a halt while the access is carried out. It forwards each access to a far-side target through a stable request bundle plus a request toggle, and completes on a synchronized acknowledge toggle. It lives in the CPU clock domain, between the bus_rv32 master signals and a target in a foreign clock domain.

## Interface
- `StartAddress`, default 'h0 — first address of the claimed window (inclusive).
- `EndAddress`, default 'h0 — last address of the claimed window (inclusive).
- `AddrWidth`, default `address_width` (package) — bus address width.
- `DataWidth`, default `data_width` (package, 32) — bus data width.
- `TimeoutCycles`, default 4096 — maximum wait for an acknowledge before the access is aborted.

- `clk_i` in 1 — CPU clock; the only clock.
- `reset_i` in 1 — asynchronous, active-low reset.
- `cpu_address_i` in AddrWidth — CPU bus address.
- `cpu_wdata_i` in DataWidth — CPU write data.
- `cpu_we_i` in 1 — 1 = write, 0 = read.
- `cpu_rdata_o` out DataWidth — read data returned to the CPU; zero when not returning data.
- `cpu_halt_o` out 1 — stalls the CPU while an access is pending.
- `tgt_req_o` out 1 — request toggle; each transition is one access.
- `tgt_address_o` out AddrWidth — captured address, stable while a request is outstanding.
- `tgt_wdata_o` out DataWidth — captured write data, stable while a request is outstanding.
- `tgt_we_o` out 1 — captured write flag, stable while a request is outstanding.
- `tgt_ack_i` in 1 — acknowledge toggle from the target (asynchronous to `clk_i`).
- `tgt_rdata_i` in DataWidth — target read data; stable from the `tgt_ack_i` toggle until the next request.
- `timeout_o` out 1 — sticky flag; set when an access times out.

## Operation
- Hit: `StartAddress <= cpu_address_i <= EndAddress`, unsigned compare.
- States: IDLE, WAIT, DONE.
- IDLE:
  - `ack_seen <= ack_s2` every cycle, so stale or post-reset ack edges are ignored.
  - On a hit: capture address, wdata and we into the `tgt_*` registers; toggle `tgt_req_o`; clear the timeout counter; go to WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - Ack edge (`ack_s2 != ack_seen`): `ack_seen <= ack_s2`; if read, capture `tgt_rdata_i` into `rdata_q`, if write, leave `rdata_q` at 0; go to DONE.
  - Counter reaches `TimeoutCycles-1` first: set `timeout_o`, set `rdata_q` to 0, go to DONE.
- DONE: one cycle, then IDLE. `rdata_q` is cleared on entry to IDLE.
- `cpu_halt_o = (IDLE & hit) | WAIT`, combinational. It is 0 in DONE, so the CPU advances exactly one access.
- `cpu_rdata_o = rdata_q` in DONE when the access was a read; 0 otherwise. Zero output allows OR-combining with other slaves.
- A hit in the cycle after DONE (same or new address) is a new, independent access.
- A late ack after a timeout is absorbed by the IDLE resync.

## Timing
- Reset values (async, `reset_i` low): state IDLE, `tgt_req_o` 0, `tgt_address_o` 0, `tgt_wdata_o` 0, `tgt_we_o` 0, `rdata_q` 0, ack sync flops 0, `ack_seen` 0, counter 0, `timeout_o` 0. `cpu_halt_o` follows hit combinationally only after reset is released.
- Reset mid-access aborts the access. The far side must be reset with this block; any residual toggle mismatch is discarded by the IDLE resync.
- Hit in cycle T: halt is high in T; `tgt_*` updated at the T+1 edge.
- `tgt_ack_i` toggles before edge k: `ack_s1` at k, `ack_s2` at k+1, detected during cycle k+1, DONE in cycle k+2 with `cpu_rdata_o` valid and halt low.
- Minimum access time is therefore 2 CPU cycles after ack arrival plus target latency.
- `tgt_rdata_i` is sampled only after 2 synchronizer stages, so it is quasi-static by protocol.

## Structure
- Package: `address_width`, `data_width`, and the state enum `bus_cdc_state_t`.
- Sub-module `sync_2ff` (parameterized width, async active-low reset) for `tgt_ack_i`.
- Far-side responder is a separate block, not part of this one.

## Test plan
- Write 0xA5A5_1234 to StartAddress; bench target acks after 7 target cycles. Expect:
  - `tgt_address_o` = StartAddress, `tgt_wdata_o` = 0xA5A5_1234, `tgt_we_o` = 1;
  - one `tgt_req_o` toggle;
  - halt high until the DONE cycle, 3 cycles after ack is seen at the input.
- Read StartAddress with target returning 0x0BAD_F00D. Expect `cpu_rdata_o` = 0x0BAD_F00D for exactly the DONE cycle, 0 otherwise.
- Address StartAddress-1 and EndAddress+1. Expect no toggle, halt 0, `cpu_rdata_o` 0. EndAddress is accepted.
- Back-to-back reads to the same address. Expect two toggles and two DONE cycles.
- No ack. Expect `timeout_o` = 1 after `TimeoutCycles`, `cpu_rdata_o` 0, halt released. A late ack is then ignored and the next access works.
- Assert `reset_i` during WAIT. Expect all outputs at reset values immediately; the next access completes normally.
